i2c_eeprom_slave: RTL

- Synthesizable I2C target that emulates a 24xx-series EEPROM with 2-byte word addressing on an FPGA.
- Answers the team's existing I2C master and EEPROM controller, so the flash-save path can run in simulation and on-board without a physical EEPROM.
- Supports byte/page write with a committed write cycle (ACK-polling busy period), current-address read, random read and sequential read.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_line_cond.sv | 39 +++
 rtl/i2c_eeprom_slave.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM states, bus condition names, ACK levels.
package i2c_pkg;
  localparam logic [6:0] DEV_ADDR_DEF = 7'h50;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, WDATA, ACK_WD, RDATA, RACK, COMMIT
  } state_t;

  typedef enum logic [1:0] {COND_NONE, COND_START, COND_STOP} cond_t;

  typedef struct packed {
    logic  sda;
    logic  scl_rise;
    logic  scl_fall;
    cond_t cond;
  } line_ev_t;
endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA synchronizers plus edge and START/STOP detection for an I2C target.
module i2c_line_cond import i2c_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  input  logic     scl_pad_i,
  input  logic     sda_pad_i,
  output line_ev_t ev
);
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s;

  // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_pad_i};
      sda_sync <= {sda_sync[0], sda_pad_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  always_comb begin
    ev.sda      = sda_s;
    ev.scl_rise = scl_s & ~scl_d;
    ev.scl_fall = ~scl_s & scl_d;
    ev.cond     = COND_NONE;
    if (scl_s && scl_d && sda_d && !sda_s)      ev.cond = COND_START;
    else if (scl_s && scl_d && !sda_d && sda_s) ev.cond = COND_STOP;
  end
endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 24xx EEPROM with 2-byte word address, page buffer and timed commit.
module i2c_eeprom_slave import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR   = DEV_ADDR_DEF,
  parameter int         MEM_AW     = 10,
  parameter int         PAGE_AW    = 5,
  parameter int         TWR_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_padoen_o,
  output logic              busy,
  input  logic [MEM_AW-1:0] bd_addr,
  output logic [7:0]        bd_data
);
  localparam int DEPTH = 2**MEM_AW;
  localparam int PAGE  = 2**PAGE_AW;
  localparam int TW    = $clog2(TWR_CYCLES+1);

  line_ev_t          ev;
  state_t            state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg, addr_hi, rx_byte;
  logic              ack_on, rw, wr_seen;
  logic [MEM_AW-1:0] ptr;
  logic [7:0]        page_buf [PAGE];
  logic [PAGE-1:0]   page_vld;
  logic [TW-1:0]     twr_cnt;
  logic [PAGE_AW:0]  cidx;
  logic [7:0]        mem [DEPTH];
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;

  i2c_line_cond u_line (
    .clk(clk), .rst(rst), .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i), .ev(ev)
  );

  assign sda_pad_o = 1'b0;
  assign rx_byte   = {shreg[6:0], ev.sda};
  // Commit walks the whole page, one slot per clk, writing only the valid ones.
  assign mem_we    = (state == COMMIT) && !rst && !cidx[PAGE_AW] && page_vld[cidx[PAGE_AW-1:0]];
  assign mem_waddr = {ptr[MEM_AW-1:PAGE_AW], cidx[PAGE_AW-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      addr_hi      <= '0;
      ack_on       <= 1'b0;
      rw           <= 1'b0;
      wr_seen      <= 1'b0;
      ptr          <= '0;
      page_vld     <= '0;
      twr_cnt      <= '0;
      cidx         <= '0;
      busy         <= 1'b0;
      sda_padoen_o <= 1'b1;
    end else if (state == COMMIT) begin
      if (!cidx[PAGE_AW]) cidx <= cidx + 1'b1;
      if (twr_cnt == TW'(TWR_CYCLES-1)) begin
        busy     <= 1'b0;
        page_vld <= '0;
        state    <= IDLE;
      end else begin
        twr_cnt <= twr_cnt + 1'b1;
      end
    end else if (ev.cond == COND_START) begin
      state   <= DEV;
      bit_cnt <= '0;
      ack_on  <= 1'b0;
      if (wr_seen) begin
        page_vld <= '0;
        wr_seen  <= 1'b0;
      end
    end else if (ev.cond == COND_STOP) begin
      bit_cnt <= '0;
      ack_on  <= 1'b0;
      if (wr_seen) begin
        state   <= COMMIT;
        busy    <= 1'b1;
        twr_cnt <= '0;
        cidx    <= '0;
        wr_seen <= 1'b0;
      end else begin
        state <= IDLE;
      end
    end else if (ev.scl_rise) begin
      case (state)
        DEV, AH, AL, WDATA: begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 4'd7) begin
            case (state)
              DEV: begin
                if (rx_byte[7:1] == DEV_ADDR && !busy) begin
                  state <= ACK_DEV;
                  rw    <= rx_byte[0];
                end else begin
                  state <= IDLE;
                end
              end
              AH: begin
                addr_hi <= rx_byte;
                state   <= ACK_AH;
              end
              AL: begin
                ptr   <= MEM_AW'({addr_hi, rx_byte});
                state <= ACK_AL;
              end
              default: begin
                page_buf[ptr[PAGE_AW-1:0]] <= rx_byte;
                page_vld[ptr[PAGE_AW-1:0]] <= 1'b1;
                ptr[PAGE_AW-1:0]           <= ptr[PAGE_AW-1:0] + 1'b1;
                wr_seen                    <= 1'b1;
                state                      <= ACK_WD;
              end
            endcase
          end
        end
        RDATA: bit_cnt <= bit_cnt + 1'b1;
        // Advance on ACK and NACK alike so a later current-address read continues.
        RACK: begin
          ptr <= ptr + 1'b1;
          if (ev.sda != ACK) state <= IDLE;
        end
        default: ;
      endcase
    end else if (ev.scl_fall) begin
      case (state)
        ACK_DEV, ACK_AH, ACK_AL, ACK_WD: begin
          if (!ack_on) begin
            ack_on       <= 1'b1;
            sda_padoen_o <= ACK;
          end else begin
            ack_on       <= 1'b0;
            bit_cnt      <= '0;
            sda_padoen_o <= 1'b1;
            case (state)
              ACK_DEV: begin
                if (rw) begin
                  shreg        <= mem[ptr];
                  sda_padoen_o <= mem[ptr][7];
                  state        <= RDATA;
                end else begin
                  state <= AH;
                end
              end
              ACK_AH:  state <= AL;
              default: state <= WDATA;
            endcase
          end
        end
        RDATA: begin
          if (bit_cnt == 4'd8) begin
            sda_padoen_o <= 1'b1;
            state        <= RACK;
          end else begin
            sda_padoen_o <= shreg[~bit_cnt[2:0]];
          end
        end
        RACK: begin
          shreg        <= mem[ptr];
          sda_padoen_o <= mem[ptr][7];
          bit_cnt      <= '0;
          state        <= RDATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= page_buf[cidx[PAGE_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) bd_data <= '0;
    else     bd_data <= mem[bd_addr];
  end
endmodule
